// File: rtl/hazard_scoreboard.sv
// Register write-pending scoreboard: per-register countdown of in-flight writes,
// decode stall generation and final-cycle bypass select.
module hazard_scoreboard #(
  parameter int unsigned          REG_BITS     = 2,
  parameter int unsigned          OP_BITS      = 3,
  parameter int unsigned          PIPE_DEPTH   = 3,
  parameter logic [OP_BITS-1:0]   ORI_OP       = OP_BITS'(3'b111),
  parameter int unsigned          IMPLICIT_REG = 1,
  parameter bit                   FWD_EN       = 1'b1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                dec_valid,
  input  logic [OP_BITS-1:0]  dec_op,
  input  logic [REG_BITS-1:0] dec_src1,
  input  logic [REG_BITS-1:0] dec_src2,
  input  logic                dec_use1,
  input  logic                dec_use2,
  input  logic [REG_BITS-1:0] dec_dst,
  input  logic                dec_wr,
  input  logic                flush,
  output logic                stall,
  output logic                fwd1,
  output logic                fwd2,
  output logic                busy,
  output logic [15:0]         stall_cycles
);

  localparam int unsigned NUM_REGS = 2 ** REG_BITS;
  localparam int unsigned CW       = $clog2(PIPE_DEPTH + 1);
  localparam logic [CW-1:0]       DEPTH_C = CW'(PIPE_DEPTH);
  localparam logic [CW-1:0]       ONE_C   = CW'(1);
  localparam logic [REG_BITS-1:0] IMP_REG = REG_BITS'(IMPLICIT_REG);

  logic [CW-1:0] cnt     [NUM_REGS];
  logic [CW-1:0] cnt_nxt [NUM_REGS];

  logic                is_ori;
  logic [REG_BITS-1:0] src1_e, src2_e, dst_e;
  logic                use1_e, use2_e, wr_e;
  logic [CW-1:0]       c1, c2;
  logic                haz1, haz2, byp1, byp2, issue;

  // Effective operands: the implicit-register opcode overrides the decoded fields
  always_comb begin
    is_ori = (dec_op == ORI_OP);
    src1_e = is_ori ? IMP_REG : dec_src1;
    use1_e = is_ori ? 1'b1    : dec_use1;
    src2_e = dec_src2;
    use2_e = is_ori ? 1'b0    : dec_use2;
    dst_e  = is_ori ? IMP_REG : dec_dst;
    wr_e   = is_ori ? 1'b1    : dec_wr;
  end

  // Hazard / bypass decision from the registered scoreboard only
  always_comb begin
    c1    = cnt[src1_e];
    c2    = cnt[src2_e];
    haz1  = use1_e && ((c1 > ONE_C) || ((c1 == ONE_C) && !FWD_EN));
    haz2  = use2_e && ((c2 > ONE_C) || ((c2 == ONE_C) && !FWD_EN));
    byp1  = use1_e && FWD_EN && (c1 == ONE_C);
    byp2  = use2_e && FWD_EN && (c2 == ONE_C);
    stall = dec_valid && (haz1 || haz2) && !flush;
    issue = dec_valid && !stall && !flush;
    fwd1  = dec_valid && !stall && byp1;
    fwd2  = dec_valid && !stall && byp2;
  end

  // Next counters: flush beats issue, issue reload beats decrement
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (flush) begin
        cnt_nxt[i] = '0;
      end else if (issue && wr_e && (dst_e == REG_BITS'(i))) begin
        cnt_nxt[i] = DEPTH_C;
      end else if (cnt[i] != '0) begin
        cnt_nxt[i] = cnt[i] - ONE_C;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) busy = busy | (cnt[i] != '0);
  end

  // Saturating stalled-cycle counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule
